// File: rtl/pwm_gen_multichan.sv
// Multi-channel PWM generator with debounced per-channel inc/dec duty buttons and
// double-buffered duty registers. Define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned) counter.
module pwm_gen_multichan #(
   parameter int NCH        = 4,
   parameter int CW         = 7,
   parameter int PERIOD     = 100,
   parameter int STEP       = 10,
   parameter int DUTY_INIT  = 50,
   parameter int DEB_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NCH-1:0]    ui_inc_duty,
   input  logic [NCH-1:0]    ui_dec_duty,
   output logic [NCH-1:0]    uo_pwm,
   output logic              period_start,
   output logic [NCH*CW-1:0] duty_o
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_M1 = DW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] PER_M1 = CW'(PERIOD - 1);
   localparam logic [CW-1:0] PER_C  = CW'(PERIOD);
   localparam logic [CW-1:0] STEP_C = CW'(STEP);
   localparam logic [CW-1:0] INIT_C = CW'(DUTY_INIT);
   localparam logic [CW:0]   PER_W  = (CW+1)'(PERIOD);
   localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);

   // Button bits: [NCH-1:0] are increase buttons, [2*NCH-1:NCH] are decrease buttons.
   logic [2*NCH-1:0] btn, sync1, sync2, deb, rise;
   logic [DW-1:0]    deb_cnt [2*NCH];

   logic [CW-1:0] shadow    [NCH];
   logic [CW-1:0] shadow_nx [NCH];
   logic [CW-1:0] active    [NCH];
   logic [CW-1:0] cnt;
   logic          boundary;

   assign btn = {ui_dec_duty, ui_inc_duty};

   always_comb begin
      rise = '0;
      for (int b = 0; b < 2*NCH; b++)
         rise[b] = sync2[b] & ~deb[b] & (deb_cnt[b] == DEB_M1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         for (int b = 0; b < 2*NCH; b++) deb_cnt[b] <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         for (int b = 0; b < 2*NCH; b++) begin
            if (sync2[b] == deb[b]) begin
               deb_cnt[b] <= '0;
            end else if (deb_cnt[b] == DEB_M1) begin
               deb[b]     <= sync2[b];
               deb_cnt[b] <= '0;
            end else begin
               deb_cnt[b] <= deb_cnt[b] + 1'b1;
            end
         end
      end
   end

   // Saturating duty arithmetic; simultaneous inc and dec cancel out.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         shadow_nx[i] = shadow[i];
         if (ena && rise[i] && !rise[NCH+i]) begin
            shadow_nx[i] = (({1'b0, shadow[i]} + STEP_W) > PER_W) ? PER_C : shadow[i] + STEP_C;
         end else if (ena && rise[NCH+i] && !rise[i]) begin
            shadow_nx[i] = ({1'b0, shadow[i]} < STEP_W) ? '0 : shadow[i] - STEP_C;
         end
      end
   end

`ifdef PWM_CENTER_ALIGN_EN
   logic down;

   assign boundary = ena & down & (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         down         <= 1'b0;
         uo_pwm       <= '0;
         period_start <= 1'b0;
      end else begin
         period_start <= boundary;
         for (int i = 0; i < NCH; i++)
            uo_pwm[i] <= ena & ({1'b0, cnt} >= (PER_W - {1'b0, active[i]}));
         if (!ena) begin
            cnt  <= '0;
            down <= 1'b0;
         end else if (!down) begin
            if (cnt == PER_M1) down <= 1'b1;
            else               cnt  <= cnt + 1'b1;
         end else begin
            if (cnt == '0) down <= 1'b0;
            else           cnt  <= cnt - 1'b1;
         end
      end
   end
`else
   assign boundary = ena & (cnt == PER_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         uo_pwm       <= '0;
         period_start <= 1'b0;
      end else begin
         period_start <= ena & (cnt == '0);
         for (int i = 0; i < NCH; i++)
            uo_pwm[i] <= ena & (cnt < active[i]);
         if (!ena || cnt == PER_M1) cnt <= '0;
         else                       cnt <= cnt + 1'b1;
      end
   end
`endif

   // Shadow takes button events at any time; active copies it only at the period boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            shadow[i] <= INIT_C;
            active[i] <= INIT_C;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            shadow[i] <= shadow_nx[i];
            if (boundary) active[i] <= shadow[i];
         end
      end
   end

   always_comb begin
      duty_o = '0;
      for (int i = 0; i < NCH; i++) duty_o[i*CW +: CW] = active[i];
   end

endmodule
